// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_fifo
// UART transmitter with an integrated transmit FIFO and gap-free framing.
// Rev    : 1.0
// ============================================================================
module uart_tx_fifo #(
    parameter  int CLK_FREQ   = 125_000_000,
    parameter  int BAUD       = 115200,
    parameter  int DATA_BITS  = 8,
    parameter  int PARITY     = 0,
    parameter  int STOP_BITS  = 1,
    parameter  int FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done,
    output logic [AW:0]          fifo_count
);

    localparam int              DIV       = CLK_FREQ / BAUD;
    localparam int              BW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [31:0]     DIV_M1    = 32'(DIV - 1);
    localparam logic [BW-1:0]   LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0]   LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0]   BIT_ONE   = BW'(1);
    localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
    localparam logic [AW:0]     CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]     CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [31:0]            baud_q, baud_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   tx_q, tx_d;
    logic                   done_q, done_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic                   push;
    logic                   pop;
    logic                   bit_end;
    logic                   nonempty;
    logic                   par_bit;
    logic [BW-1:0]          bit_nx;

    assign tx_ready   = (count_q != CNT_FULL);
    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign fifo_count = count_q;

    assign push     = tx_valid && tx_ready;
    assign nonempty = (count_q != '0);
    assign bit_end  = (baud_q == DIV_M1);
    assign bit_nx   = bit_q + BIT_ONE;
    assign par_bit  = (PARITY == 1) ? ~^data_q : ^data_q;

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        data_d   = data_q;
        tx_d     = tx_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
                bit_d  = '0;
                if (nonempty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    tx_d    = data_q[0];
                end else begin
                    baud_d = baud_q + 32'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == LAST_DATA) begin
                        bit_d = '0;
                        if (PARITY != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_bit;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_nx;
                        tx_d  = data_q[bit_nx];
                    end
                end else begin
                    baud_d = baud_q + 32'd1;
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + 32'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == LAST_STOP) begin
                        bit_d = '0;
                        // Chain straight into the next start bit when data is waiting.
                        if (nonempty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_nx;
                    end
                end else begin
                    baud_d = baud_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        if (pop) begin
            data_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // Registered pulse, high during the final cycle of the last stop bit.
        done_d = (state_d == S_STOP) && (baud_d == DIV_M1) && (bit_d == LAST_STOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            data_q   <= '0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            data_q   <= data_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

endmodule
`default_nettype wire
